rv_imem_responder: RTL and testbench

RV_IMEM_RESPONDER -- requirements
Module: rv_imem_responder

---
 rtl/rv_imem_responder.sv | 168 ++++++++++++++++
 tb/tb_rv_imem_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv_imem_responder.sv
// -----------------------------------------------------------------------------
// rv_imem_responder
//
// Instruction-fetch responder with a one-entry line buffer. A fetch whose word
// address matches the buffered word is answered one cycle later without going
// to memory. Any other fetch issues a single read to the memory port and
// answers with the returned word. A fetch that is withdrawn or redirected while
// the read is outstanding still refills the buffer but is not acknowledged.
// i_inval (fence.i) drops the buffered word.
//
// Ports
//   i_clk, i_reset_n  clock, asynchronous active-low reset
//   i_cyc, i_addr     fetch request and byte address (bits [1:0] ignored)
//   i_inval           invalidate the line buffer
//   o_instruction     fetched word, held between acks
//   o_ack             one-cycle response strobe
//   o_mem_req         memory read request, held with o_mem_addr until i_mem_gnt
//   o_mem_addr        memory word address
//   i_mem_gnt         memory accepted the request
//   i_mem_rvalid      read data valid (only honoured while waiting for it)
//   i_mem_rdata       read data
//   o_busy            FSM is not idle
// -----------------------------------------------------------------------------
module rv_imem_responder #(
   parameter int IADDR_SPACE_BITS = 16,
   parameter int MEM_ADDR_BITS    = IADDR_SPACE_BITS - 2
) (
   input  logic                     i_clk,
   input  logic                     i_reset_n,
   input  logic                     i_cyc,
   input  logic [IADDR_SPACE_BITS-1:0] i_addr,
   input  logic                     i_inval,
   output logic [31:0]              o_instruction,
   output logic                     o_ack,
   output logic                     o_mem_req,
   output logic [MEM_ADDR_BITS-1:0] o_mem_addr,
   input  logic                     i_mem_gnt,
   input  logic                     i_mem_rvalid,
   input  logic [31:0]              i_mem_rdata,
   output logic                     o_busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_RESP
   } state_t;

   state_t                   state;
   logic [MEM_ADDR_BITS-1:0] req_addr;
   logic [MEM_ADDR_BITS-1:0] buf_addr;
   logic [31:0]              buf_data;
   logic                     buf_valid;
   logic                     stale;
   logic                     inval_seen;

   logic [MEM_ADDR_BITS-1:0] word_addr;
   logic                     hit;
   logic                     addr_moved;
   logic                     stale_now;
   logic                     refill;
   logic                     unused_byte_bits;

   // Byte offset within the word is irrelevant for a 32-bit fetch.
   assign unused_byte_bits = ^i_addr[1:0];

   // The cast zero-extends or truncates the word address to the port width.
   assign word_addr  = MEM_ADDR_BITS'(i_addr[IADDR_SPACE_BITS-1:2]);
   assign hit        = buf_valid && (buf_addr == word_addr) && !i_inval;
   assign addr_moved = !i_cyc || (word_addr != req_addr);
   // The rvalid cycle itself can make the fetch stale, so fold it in here.
   assign stale_now  = stale || addr_moved;
   assign refill     = (state == S_WAIT) && i_mem_rvalid;
   assign o_busy     = (state != S_IDLE);

   // NOTE: buf_data is a pure payload guarded by buf_valid, so it carries no
   // reset; keeping it out of the reset network lets it map to plain flops.
   always_ff @(posedge i_clk) begin
      if (refill) begin
         buf_data <= i_mem_rdata;
      end
   end

   // NOTE: all state here is updated with non-blocking assignments, so every
   // test in this block sees the values from before the current edge.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state         <= S_IDLE;
         o_ack         <= 1'b0;
         o_mem_req     <= 1'b0;
         o_mem_addr    <= '0;
         o_instruction <= '0;
         req_addr      <= '0;
         buf_addr      <= '0;
         buf_valid     <= 1'b0;
         stale         <= 1'b0;
         inval_seen    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_cyc) begin
                  if (hit) begin
                     o_instruction <= buf_data;
                     o_ack         <= 1'b1;
                     state         <= S_RESP;
                  end else begin
                     req_addr   <= word_addr;
                     o_mem_addr <= word_addr;
                     o_mem_req  <= 1'b1;
                     state      <= S_REQ;
                  end
               end
            end

            S_REQ: begin
               // A grant wins over a simultaneous withdrawal: the read is
               // already committed at the memory.
               if (i_mem_gnt) begin
                  o_mem_req  <= 1'b0;
                  stale      <= 1'b0;
                  inval_seen <= 1'b0;
                  state      <= S_WAIT;
               end else if (addr_moved) begin
                  o_mem_req <= 1'b0;
                  state     <= S_IDLE;
               end
            end

            S_WAIT: begin
               if (i_mem_rvalid) begin
                  buf_addr  <= req_addr;
                  buf_valid <= !(inval_seen || i_inval);
                  stale     <= 1'b0;
                  if (stale_now) begin
                     state <= S_IDLE;
                  end else begin
                     o_instruction <= i_mem_rdata;
                     o_ack         <= 1'b1;
                     state         <= S_RESP;
                  end
               end else begin
                  stale      <= stale_now;
                  inval_seen <= inval_seen || i_inval;
               end
            end

            S_RESP: begin
               o_ack <= 1'b0;
               state <= S_IDLE;
            end

            default: begin
               o_ack     <= 1'b0;
               o_mem_req <= 1'b0;
               state     <= S_IDLE;
            end
         endcase

         // Invalidate in any state; as the last assignment it overrides a
         // refill in the same cycle.
         if (i_inval) begin
            buf_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rv_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_rv_imem_responder
//
// Directed bench for rv_imem_responder: cold miss, hit, redirect during the
// memory wait, request withdrawn before grant, invalidate concurrent with read
// data, and reset while a read is outstanding.
// -----------------------------------------------------------------------------
module tb_rv_imem_responder;

   localparam int IADDR_SPACE_BITS = 16;
   localparam int MEM_ADDR_BITS    = IADDR_SPACE_BITS - 2;

   logic                        i_clk;
   logic                        i_reset_n;
   logic                        i_cyc;
   logic [IADDR_SPACE_BITS-1:0] i_addr;
   logic                        i_inval;
   logic [31:0]                 o_instruction;
   logic                        o_ack;
   logic                        o_mem_req;
   logic [MEM_ADDR_BITS-1:0]    o_mem_addr;
   logic                        i_mem_gnt;
   logic                        i_mem_rvalid;
   logic [31:0]                 i_mem_rdata;
   logic                        o_busy;

   int checks = 0;
   int errors = 0;

   rv_imem_responder #(
      .IADDR_SPACE_BITS(IADDR_SPACE_BITS),
      .MEM_ADDR_BITS   (MEM_ADDR_BITS)
   ) dut (
      .i_clk        (i_clk),
      .i_reset_n    (i_reset_n),
      .i_cyc        (i_cyc),
      .i_addr       (i_addr),
      .i_inval      (i_inval),
      .o_instruction(o_instruction),
      .o_ack        (o_ack),
      .o_mem_req    (o_mem_req),
      .o_mem_addr   (o_mem_addr),
      .i_mem_gnt    (i_mem_gnt),
      .i_mem_rvalid (i_mem_rvalid),
      .i_mem_rdata  (i_mem_rdata),
      .o_busy       (o_busy)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      i_reset_n    = 1'b0;
      i_cyc        = 1'b0;
      i_addr       = '0;
      i_inval      = 1'b0;
      i_mem_gnt    = 1'b0;
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = '0;

      // ---------------- reset state ----------------
      #2;
      check("rst_ack",   32'(o_ack),         32'h0);
      check("rst_req",   32'(o_mem_req),     32'h0);
      check("rst_maddr", 32'(o_mem_addr),    32'h0);
      check("rst_instr", o_instruction,      32'h0);
      check("rst_busy",  32'(o_busy),        32'h0);
      tick();
      i_reset_n = 1'b1;

      // ---------------- cold miss at 0x0010 ----------------
      i_cyc  = 1'b1;
      i_addr = 16'h0010;
      tick();
      check("cold_req",   32'(o_mem_req),  32'h1);
      check("cold_maddr", 32'(o_mem_addr), 32'h004);
      check("cold_busy",  32'(o_busy),     32'h1);
      check("cold_noack", 32'(o_ack),      32'h0);
      tick();                              // request held while not granted
      check("cold_hold_req",   32'(o_mem_req),  32'h1);
      check("cold_hold_maddr", 32'(o_mem_addr), 32'h004);
      i_mem_gnt = 1'b1;
      tick();
      i_mem_gnt = 1'b0;
      check("cold_req_drop", 32'(o_mem_req), 32'h0);
      tick();
      check("cold_wait_noack", 32'(o_ack), 32'h0);
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 32'h0000_0013;
      tick();
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = 32'hDEAD_BEEF;
      check("cold_ack",   32'(o_ack),     32'h1);
      check("cold_instr", o_instruction,  32'h0000_0013);
      check("cold_bvalid", 32'(dut.buf_valid), 32'h1);

      // ---------------- hit at 0x0012 (same word) ----------------
      i_addr = 16'h0012;
      tick();                              // RESP -> IDLE
      check("ack_one_cycle", 32'(o_ack),  32'h0);
      check("resp_idle",     32'(o_busy), 32'h0);
      check("instr_hold",    o_instruction, 32'h0000_0013);
      tick();                              // hit evaluated in IDLE
      check("hit_ack",   32'(o_ack),     32'h1);
      check("hit_instr", o_instruction,  32'h0000_0013);
      check("hit_noreq", 32'(o_mem_req), 32'h0);
      i_cyc = 1'b0;
      tick();
      check("hit_ack_drop", 32'(o_ack), 32'h0);

      // ---------------- redirect during WAIT ----------------
      i_cyc  = 1'b1;
      i_addr = 16'h0020;
      tick();
      check("redir_req",   32'(o_mem_req),  32'h1);
      check("redir_maddr", 32'(o_mem_addr), 32'h008);
      i_mem_gnt = 1'b1;
      tick();
      i_mem_gnt = 1'b0;
      i_addr    = 16'h0100;
      tick();
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 32'hAAAA_0001;
      tick();
      i_mem_rvalid = 1'b0;
      check("redir_noack",  32'(o_ack),          32'h0);
      check("redir_idle",   32'(o_busy),         32'h0);
      check("redir_instr",  o_instruction,       32'h0000_0013);
      check("redir_baddr",  32'(dut.buf_addr),   32'h008);
      check("redir_bvalid", 32'(dut.buf_valid),  32'h1);
      tick();                              // new fetch for 0x0100 misses
      check("redir_new_req",   32'(o_mem_req),  32'h1);
      check("redir_new_maddr", 32'(o_mem_addr), 32'h040);
      i_mem_gnt = 1'b1;
      tick();
      i_mem_gnt    = 1'b0;
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 32'h0010_0093;
      tick();
      i_mem_rvalid = 1'b0;
      check("redir_new_ack",   32'(o_ack),    32'h1);
      check("redir_new_instr", o_instruction, 32'h0010_0093);
      i_cyc = 1'b0;
      tick();

      // ---------------- request withdrawn in REQ ----------------
      i_cyc  = 1'b1;
      i_addr = 16'h0200;
      tick();
      check("wd_req",   32'(o_mem_req),  32'h1);
      check("wd_maddr", 32'(o_mem_addr), 32'h080);
      i_cyc = 1'b0;
      tick();
      check("wd_req_drop", 32'(o_mem_req), 32'h0);
      check("wd_idle",     32'(o_busy),    32'h0);
      check("wd_noack",    32'(o_ack),     32'h0);
      i_mem_rvalid = 1'b1;                 // stray rvalid in IDLE is ignored
      i_mem_rdata  = 32'h5555_5555;
      tick();
      i_mem_rvalid = 1'b0;
      check("wd_stray_noack", 32'(o_ack),   32'h0);
      check("wd_stray_instr", o_instruction, 32'h0010_0093);

      // ---------------- i_inval concurrent with rvalid ----------------
      i_cyc  = 1'b1;
      i_addr = 16'h0300;
      tick();
      check("inv_req",   32'(o_mem_req),  32'h1);
      check("inv_maddr", 32'(o_mem_addr), 32'h0C0);
      i_mem_gnt = 1'b1;
      tick();
      i_mem_gnt    = 1'b0;
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 32'h1234_5678;
      i_inval      = 1'b1;
      tick();
      i_mem_rvalid = 1'b0;
      i_inval      = 1'b0;
      check("inv_ack",    32'(o_ack),         32'h1);
      check("inv_instr",  o_instruction,      32'h1234_5678);
      check("inv_bvalid", 32'(dut.buf_valid), 32'h0);
      tick();                              // RESP -> IDLE
      tick();                              // same address misses again
      check("inv_refetch_req",   32'(o_mem_req),  32'h1);
      check("inv_refetch_maddr", 32'(o_mem_addr), 32'h0C0);
      check("inv_refetch_noack", 32'(o_ack),      32'h0);

      // ---------------- reset mid-WAIT ----------------
      i_mem_gnt = 1'b1;
      tick();
      i_mem_gnt = 1'b0;
      check("rw_in_wait", 32'(o_busy), 32'h1);
      i_reset_n = 1'b0;
      #2;
      check("rw_rst_busy", 32'(o_busy),    32'h0);
      check("rw_rst_req",  32'(o_mem_req), 32'h0);
      i_reset_n    = 1'b1;
      i_cyc        = 1'b0;
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 32'hCAFE_F00D;
      tick();
      i_mem_rvalid = 1'b0;
      check("rw_noack",  32'(o_ack),         32'h0);
      check("rw_noreq",  32'(o_mem_req),     32'h0);
      check("rw_bvalid", 32'(dut.buf_valid), 32'h0);
      check("rw_instr",  o_instruction,      32'h0);
      tick();
      check("rw_noack2", 32'(o_ack), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
